ofdm_symbol_framer: RTL and testbench
=====================================

# ofdm_symbol_framer

Transmit-side OFDM symbol framer. It sits between the IFFT output stream and the DAC sample path, and buffers one complete time-domain OFDM symbol. It emits each symbol as a framed packet in three parts: a silent guard interval, a constant-amplitude preamble burst, and the symbol samples negated per component. The burst gives the receiver's moving-average symbol detector a clean step to trigger on. The negation pre-compensates the receiver's per-component negation, so end-to-end the samples come out unchanged.

## Interface
Parameters:
- OFDM_SYMBOL_LENGTH, 64: samples per symbol; also the buffer depth.
- GUARD_LENGTH, 32: zero-valued beats emitted before the preamble. Must be at least 32 so the receiver's 32-sample average settles.
- PREAMBLE_LENGTH, 8: preamble beats.
- PREAMBLE_AMPLITUDE, 16'sh2000: signed value driven on both I and Q during the preamble.

Ports (one clock; reset is asynchronous and active-high):
- clock_clk  in  1  system clock.
- reset_reset  in  1  asynchronous, active-high reset.
- asi_in0_data  in  32  input sample: [31:16] real, [15:0] imag, both signed.
- asi_in0_valid  in  1  input beat valid.
- asi_in0_startofpacket  in  1  first sample of a symbol.
- asi_in0_endofpacket  in  1  last sample of a symbol.
- asi_in0_ready  out  1  framer can accept a beat (ready latency 0).
- aso_out0_data  out  32  output sample, same packing as the input.
- aso_out0_valid  out  1  output beat valid.
- aso_out0_ready  in  1  downstream accepts a beat (ready latency 0).
- aso_out0_startofpacket  out  1  asserted on the first guard beat.
- aso_out0_endofpacket  out  1  asserted on the last payload beat.
- frame_error  out  1  one-cycle pulse when a malformed input packet is dropped.
- symbol_count  out  16  count of symbols fully transmitted; wraps 16'hFFFF -> 0.

## Operation
- States: FILL -> GUARD -> PREAMBLE -> PAYLOAD -> FILL.
- A beat is accepted on the input when asi_in0_valid && asi_in0_ready.
- A beat is transferred on the output when aso_out0_valid && aso_out0_ready.
- FILL:
  - asi_in0_ready = 1.
  - An accepted beat with SOP is written to address 0 and sets wr_idx to 1. This applies even mid-packet: the partial symbol is silently restarted.
  - Accepted beats while no packet is open are dropped.
  - EOP accepted at wr_idx == OFDM_SYMBOL_LENGTH-1: the symbol is complete; go to GUARD.
  - EOP accepted at any other index: drop the packet, pulse frame_error, wait for the next SOP.
  - Reaching index OFDM_SYMBOL_LENGTH-1 with no EOP (or a beat past the last index): drop the packet, pulse frame_error, wait for the next SOP.
  - SOP and EOP together on one beat: a length-1 packet. It is an error unless OFDM_SYMBOL_LENGTH == 1.
- GUARD: drive data 32'h0 for GUARD_LENGTH transfers. SOP is set on the first of these.
- PREAMBLE: drive {PREAMBLE_AMPLITUDE, PREAMBLE_AMPLITUDE} for PREAMBLE_LENGTH transfers.
- PAYLOAD:
  - Read the buffer from address 0 upward and drive {-re, -im}.
  - Negation is 16-bit two's complement with wrap: 16'h8000 stays 16'h8000, and 0 stays 0.
  - EOP is set on transfer OFDM_SYMBOL_LENGTH-1. After that transfer: symbol_count increments and the state returns to FILL.
- asi_in0_ready is 0 in GUARD, PREAMBLE and PAYLOAD, so the next symbol is never overwritten during readout.
- Output registers are the only source of aso_out0_*. While aso_out0_valid && !aso_out0_ready, data, SOP and EOP hold stable.
- Beat counters are sized with clog2 of the largest count parameter plus 1. A single beat counter shared across states is allowed.

## Timing
- Reset values: asi_in0_ready 0, aso_out0_valid 0, aso_out0_data 0, aso_out0_startofpacket 0, aso_out0_endofpacket 0, frame_error 0, symbol_count 0. State resets to FILL and wr_idx to 0.
- First clock edge after reset deassertion: asi_in0_ready = 1.
- The edge that accepts the completing EOP beat also drops asi_in0_ready and raises aso_out0_valid with the first guard beat. Latency from last input beat to first output beat is 1 cycle.
- aso_out0_valid stays high continuously from the first guard beat to the last payload beat. There are no gaps, so stalls come only from aso_out0_ready.
- Per symbol:
  - G+P+N output transfers, where G = GUARD_LENGTH, P = PREAMBLE_LENGTH, N = OFDM_SYMBOL_LENGTH.
  - Without backpressure: N input cycles, then G+P+N output cycles.
  - Defaults: 64 + 104.
- The edge that transfers the last payload beat clears aso_out0_valid and EOP and sets asi_in0_ready = 1.
- The buffer is single-port synchronous RAM or registers. The read address is issued one cycle ahead so the payload streams with no bubble.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). Any partial or buffered symbol is discarded. symbol_count returns to 0.

## Test plan
- Clean symbol:
  - Stimulus: SOP, samples re=k, im=-k for k=0..63, EOP at k=63; aso_out0_ready held 1.
  - Response: 32 beats of 0 with SOP on the first; 8 beats of 32'h20002000; then {-k, k} for k=0..63 with EOP on k=63. symbol_count = 1.
- Backpressure:
  - Stimulus: same symbol; aso_out0_ready toggles 1/0 pseudo-randomly.
  - Response: identical output sequence; data stable on every stall; 104 transfers total.
- Negation edges:
  - Stimulus: samples 16'h8000, 16'h7FFF, 0.
  - Response: outputs 16'h8000, 16'h8001, 0 on both I and Q.
- Malformed input:
  - Stimulus: EOP at index 40; then a 70-beat packet with no EOP; then a clean packet.
  - Response: frame_error pulses twice; only the clean symbol is framed; symbol_count = 1.
- SOP restart:
  - Stimulus: 20 beats, then a new SOP followed by 64 beats with EOP.
  - Response: payload equals the second packet only; no frame_error.
- Reset mid-PAYLOAD:
  - Stimulus: assert reset_reset during payload beat 10.
  - Response: all outputs go to reset values asynchronously. After release, the next clean symbol frames correctly with symbol_count = 1.

Source files
------------

// File: rtl/ofdm_symbol_framer.sv
// Transmit-side OFDM symbol framer: buffers one IFFT symbol, then emits it as
// guard zeros, a constant-amplitude preamble burst and the negated samples.
module ofdm_symbol_framer #(
    parameter int                 OFDM_SYMBOL_LENGTH = 64,
    parameter int                 GUARD_LENGTH       = 32,
    parameter int                 PREAMBLE_LENGTH    = 8,
    parameter logic signed [15:0] PREAMBLE_AMPLITUDE = 16'sh2000
) (
    input  logic        clock_clk,
    input  logic        reset_reset,
    input  logic [31:0] asi_in0_data,
    input  logic        asi_in0_valid,
    input  logic        asi_in0_startofpacket,
    input  logic        asi_in0_endofpacket,
    output logic        asi_in0_ready,
    output logic [31:0] aso_out0_data,
    output logic        aso_out0_valid,
    input  logic        aso_out0_ready,
    output logic        aso_out0_startofpacket,
    output logic        aso_out0_endofpacket,
    output logic        frame_error,
    output logic [15:0] symbol_count
);

    localparam int MAX_GP  = (GUARD_LENGTH > PREAMBLE_LENGTH) ? GUARD_LENGTH : PREAMBLE_LENGTH;
    localparam int MAX_LEN = (MAX_GP > OFDM_SYMBOL_LENGTH) ? MAX_GP : OFDM_SYMBOL_LENGTH;
    localparam int CW      = $clog2(MAX_LEN) + 1;
    localparam int AW      = (OFDM_SYMBOL_LENGTH > 1) ? $clog2(OFDM_SYMBOL_LENGTH) : 1;

    localparam logic [1:0] S_FILL     = 2'd0;
    localparam logic [1:0] S_GUARD    = 2'd1;
    localparam logic [1:0] S_PREAMBLE = 2'd2;
    localparam logic [1:0] S_PAYLOAD  = 2'd3;

    localparam logic [CW-1:0] LAST_GUARD    = CW'(GUARD_LENGTH - 1);
    localparam logic [CW-1:0] LAST_PREAMBLE = CW'(PREAMBLE_LENGTH - 1);
    localparam logic [CW-1:0] LAST_PAYLOAD  = CW'(OFDM_SYMBOL_LENGTH - 1);
    localparam logic [AW-1:0] LAST_IDX      = AW'(OFDM_SYMBOL_LENGTH - 1);

    logic [1:0]    r_state;
    logic          r_open;
    logic [AW-1:0] r_wrIdx;
    logic [CW-1:0] r_beat;
    logic [31:0]   r_mem [OFDM_SYMBOL_LENGTH];
    logic          r_inReady;
    logic          r_outValid;
    logic [31:0]   r_outData;
    logic          r_outSop;
    logic          r_outEop;
    logic          r_frameErr;
    logic [15:0]   r_symCount;

    logic          w_inAccept;
    logic          w_outXfer;
    logic          w_wrEn;
    logic [AW-1:0] w_wrAddr;
    logic [CW-1:0] w_beatNext;
    logic [AW-1:0] w_rdAddr;
    logic [31:0]   w_rdWord;
    logic [31:0]   w_negWord;
    logic          w_start;
    logic          w_advance;
    logic          w_complete;
    logic          w_error;

    assign w_inAccept = asi_in0_valid && r_inReady;
    assign w_outXfer  = r_outValid && aso_out0_ready;
    assign w_wrEn     = w_inAccept && (r_state == S_FILL) && (asi_in0_startofpacket || r_open);
    assign w_wrAddr   = asi_in0_startofpacket ? '0 : r_wrIdx;
    assign w_beatNext = r_beat + 1'b1;

    // Read address runs one beat ahead of the output register so payload streams without bubbles.
    assign w_rdAddr  = (r_state == S_PAYLOAD && r_beat != LAST_PAYLOAD) ? w_beatNext[AW-1:0] : '0;
    assign w_rdWord  = r_mem[w_rdAddr];
    assign w_negWord = {16'd0 - w_rdWord[31:16], 16'd0 - w_rdWord[15:0]};

    // Classify each accepted input beat against the packet currently being buffered.
    always_comb begin
        w_start    = 1'b0;
        w_advance  = 1'b0;
        w_complete = 1'b0;
        w_error    = 1'b0;
        if (r_state == S_FILL && w_inAccept) begin
            if (asi_in0_startofpacket) begin
                if (OFDM_SYMBOL_LENGTH == 1) begin
                    w_complete = asi_in0_endofpacket;
                    w_error    = !asi_in0_endofpacket;
                end else if (asi_in0_endofpacket) begin
                    w_error = 1'b1;
                end else begin
                    w_start = 1'b1;
                end
            end else if (r_open) begin
                if (r_wrIdx == LAST_IDX) begin
                    w_complete = asi_in0_endofpacket;
                    w_error    = !asi_in0_endofpacket;
                end else if (asi_in0_endofpacket) begin
                    w_error = 1'b1;
                end else begin
                    w_advance = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock_clk) begin
        if (w_wrEn) begin
            r_mem[w_wrAddr] <= asi_in0_data;
        end
    end

    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state    <= S_FILL;
            r_open     <= 1'b0;
            r_wrIdx    <= '0;
            r_beat     <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= 32'h0;
            r_outSop   <= 1'b0;
            r_outEop   <= 1'b0;
            r_frameErr <= 1'b0;
            r_symCount <= 16'h0;
        end else begin
            r_frameErr <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_start) begin
                        r_open  <= 1'b1;
                        r_wrIdx <= AW'(1);
                    end
                    if (w_advance) begin
                        r_wrIdx <= r_wrIdx + 1'b1;
                    end
                    if (w_error) begin
                        r_frameErr <= 1'b1;
                        r_open     <= 1'b0;
                        r_wrIdx    <= '0;
                    end
                    if (w_complete) begin
                        r_state    <= S_GUARD;
                        r_open     <= 1'b0;
                        r_wrIdx    <= '0;
                        r_beat     <= '0;
                        r_inReady  <= 1'b0;
                        r_outValid <= 1'b1;
                        r_outData  <= 32'h0;
                        r_outSop   <= 1'b1;
                        r_outEop   <= 1'b0;
                    end else begin
                        r_inReady <= 1'b1;
                    end
                end
                S_GUARD: begin
                    if (w_outXfer) begin
                        r_outSop <= 1'b0;
                        if (r_beat == LAST_GUARD) begin
                            r_state   <= S_PREAMBLE;
                            r_beat    <= '0;
                            r_outData <= {PREAMBLE_AMPLITUDE, PREAMBLE_AMPLITUDE};
                        end else begin
                            r_beat    <= w_beatNext;
                            r_outData <= 32'h0;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (w_outXfer) begin
                        if (r_beat == LAST_PREAMBLE) begin
                            r_state   <= S_PAYLOAD;
                            r_beat    <= '0;
                            r_outData <= w_negWord;
                            r_outEop  <= (OFDM_SYMBOL_LENGTH == 1);
                        end else begin
                            r_beat <= w_beatNext;
                        end
                    end
                end
                default: begin
                    if (w_outXfer) begin
                        if (r_beat == LAST_PAYLOAD) begin
                            r_state    <= S_FILL;
                            r_beat     <= '0;
                            r_outValid <= 1'b0;
                            r_outEop   <= 1'b0;
                            r_outData  <= 32'h0;
                            r_inReady  <= 1'b1;
                            r_symCount <= r_symCount + 16'd1;
                        end else begin
                            r_beat    <= w_beatNext;
                            r_outData <= w_negWord;
                            r_outEop  <= (w_beatNext == LAST_PAYLOAD);
                        end
                    end
                end
            endcase
        end
    end

    assign asi_in0_ready          = r_inReady;
    assign aso_out0_valid         = r_outValid;
    assign aso_out0_data          = r_outData;
    assign aso_out0_startofpacket = r_outSop;
    assign aso_out0_endofpacket   = r_outEop;
    assign frame_error            = r_frameErr;
    assign symbol_count           = r_symCount;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Bench for ofdm_symbol_framer: a packet-level model builds the expected frame
// stream, and a monitor compares every output transfer against it.
module tb_ofdm_symbol_framer;

    localparam int N = 64;
    localparam int G = 32;
    localparam int P = 8;

    logic        clock_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] asi_in0_data = 32'h0;
    logic        asi_in0_valid = 1'b0;
    logic        asi_in0_startofpacket = 1'b0;
    logic        asi_in0_endofpacket = 1'b0;
    logic        asi_in0_ready;
    logic [31:0] aso_out0_data;
    logic        aso_out0_valid;
    logic        aso_out0_ready = 1'b1;
    logic        aso_out0_startofpacket;
    logic        aso_out0_endofpacket;
    logic        frame_error;
    logic [15:0] symbol_count;

    int checks = 0;
    int failures = 0;

    logic [33:0] expQ[$];
    logic [33:0] obsQ[$];
    logic [31:0] pkt[$];
    bit          pktOpen = 0;
    int          expErr = 0;
    int          obsErr = 0;
    int          expSym = 0;
    int          xferCount = 0;
    bit          bpMode = 0;
    bit          stallPrev = 0;
    logic [33:0] stallVal = '0;

    wire [33:0] w_act = {aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_data};

    ofdm_symbol_framer dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .asi_in0_data           (asi_in0_data),
        .asi_in0_valid          (asi_in0_valid),
        .asi_in0_startofpacket  (asi_in0_startofpacket),
        .asi_in0_endofpacket    (asi_in0_endofpacket),
        .asi_in0_ready          (asi_in0_ready),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .frame_error            (frame_error),
        .symbol_count           (symbol_count)
    );

    always #5 clock_clk = ~clock_clk;

    // Downstream ready: steady or pseudo-random, changed just after each rising edge.
    always @(posedge clock_clk) begin
        #1;
        aso_out0_ready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] negate(input logic [31:0] s);
        int re;
        int im;
        re = int'(signed'(s[31:16]));
        im = int'(signed'(s[15:0]));
        return {16'(-re), 16'(-im)};
    endfunction

    task automatic pushFrame();
        for (int i = 0; i < G; i++) expQ.push_back({(i == 0), 1'b0, 32'h0});
        for (int i = 0; i < P; i++) expQ.push_back({2'b00, 32'h20002000});
        for (int i = 0; i < N; i++) expQ.push_back({1'b0, (i == N - 1), negate(pkt[i])});
        expSym++;
    endtask

    // Packet rules: a symbol is good only if it opens with SOP and closes with EOP on beat N.
    task automatic modelBeat(input bit sop, input bit eop, input logic [31:0] d);
        if (sop) begin
            pkt.delete();
            pkt.push_back(d);
            pktOpen = 1;
        end else if (!pktOpen) begin
            return;
        end else begin
            pkt.push_back(d);
        end
        if (eop || pkt.size() == N) begin
            if (eop && pkt.size() == N) pushFrame();
            else expErr++;
            pktOpen = 0;
        end
    endtask

    task automatic sendBeat(input bit sop, input bit eop, input logic [31:0] d);
        int n;
        @(negedge clock_clk);
        asi_in0_valid = 1'b1;
        asi_in0_startofpacket = sop;
        asi_in0_endofpacket = eop;
        asi_in0_data = d;
        n = 0;
        while (!asi_in0_ready && n < 3000) begin
            @(negedge clock_clk);
            n++;
        end
        checks++;
        if (!asi_in0_ready) begin
            failures++;
            $display("[TB] FAIL input_ready_timeout actual=0 required=1");
        end else begin
            modelBeat(sop, eop, d);
        end
    endtask

    task automatic releaseInput();
        @(negedge clock_clk);
        asi_in0_valid = 1'b0;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket = 1'b0;
    endtask

    // pattern 0: ramp re=k im=-k; 1: random; 2: negation edge samples then random.
    task automatic applyStimulus(input int len, input int eopAt, input int pattern, input bit release_);
        logic [31:0] d;
        for (int k = 0; k < len; k++) begin
            if (pattern == 0) d = {16'(k), 16'(-k)};
            else if (pattern == 2 && k == 0) d = 32'h80008000;
            else if (pattern == 2 && k == 1) d = 32'h7FFF7FFF;
            else if (pattern == 2 && k == 2) d = 32'h00000000;
            else d = $urandom;
            sendBeat(k == 0, k == eopAt, d);
        end
        if (release_) releaseInput();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 36'(asi_in0_ready), 36'd0);
        checkOutput({tag, "_out_valid"}, 36'(aso_out0_valid), 36'd0);
        checkOutput({tag, "_out_data"}, 36'(aso_out0_data), 36'd0);
        checkOutput({tag, "_out_sop"}, 36'(aso_out0_startofpacket), 36'd0);
        checkOutput({tag, "_out_eop"}, 36'(aso_out0_endofpacket), 36'd0);
        checkOutput({tag, "_frame_error"}, 36'(frame_error), 36'd0);
        checkOutput({tag, "_symbol_count"}, 36'(symbol_count), 36'd0);
    endtask

    task automatic applyReset();
        @(negedge clock_clk);
        reset_reset = 1'b1;
        asi_in0_valid = 1'b0;
        asi_in0_startofpacket = 1'b0;
        asi_in0_endofpacket = 1'b0;
        expQ.delete();
        obsQ.delete();
        pkt.delete();
        pktOpen = 0;
        expErr = 0;
        obsErr = 0;
        expSym = 0;
        xferCount = 0;
        #1;
        checkResetValues("reset");
        @(negedge clock_clk);
        @(negedge clock_clk);
        reset_reset = 1'b0;
        @(posedge clock_clk);
        #1;
        checkOutput("ready_after_reset", 36'(asi_in0_ready), 36'd1);
    endtask

    task automatic drainAndCheck(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || aso_out0_valid) && n < 3000) begin
            @(negedge clock_clk);
            n++;
        end
        checkOutput({name, "_drain_timeout"}, 36'(n >= 3000), 36'd0);
        checkOutput({name, "_symbol_count"}, 36'(symbol_count), 36'(expSym));
        checkOutput({name, "_frame_errors"}, 36'(obsErr), 36'(expErr));
    endtask

    task automatic checkObs(input string name, input int idx, input logic [33:0] exp);
        checks++;
        if (idx >= obsQ.size()) begin
            failures++;
            $display("[TB] FAIL %s actual=missing(size %0d) required=%h", name, obsQ.size(), exp);
        end else if (obsQ[idx] !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, obsQ[idx], exp);
        end
    endtask

    // Compare process: every output transfer, every stall hold, and input-ready exclusion.
    always @(negedge clock_clk) begin
        if (reset_reset) begin
            stallPrev = 0;
        end else begin
            if (frame_error) obsErr++;
            if (stallPrev) checkOutput("stall_hold", {1'b0, aso_out0_valid, w_act}, {1'b0, 1'b1, stallVal});
            if (aso_out0_valid) checkOutput("in_ready_during_output", 36'(asi_in0_ready), 36'd0);
            if (aso_out0_valid && aso_out0_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_beat actual=%h required=none", w_act);
                end else begin
                    checkOutput("out_beat", 36'(w_act), 36'(expQ.pop_front()));
                end
                obsQ.push_back(w_act);
                xferCount++;
            end
            stallPrev = aso_out0_valid && !aso_out0_ready;
            stallVal = w_act;
        end
    end

    initial begin
        int n;

        // Clean symbol, no backpressure
        bpMode = 0;
        applyReset();
        applyStimulus(N, N - 1, 0, 1);
        drainAndCheck("clean");
        checkOutput("clean_symbol_count_lit", 36'(symbol_count), 36'd1);
        checkOutput("clean_transfers_lit", 36'(obsQ.size()), 36'd104);
        checkObs("clean_first_guard", 0, {2'b10, 32'h0});
        checkObs("clean_first_preamble", 32, {2'b00, 32'h20002000});
        checkObs("clean_payload1", 41, {2'b00, 32'hFFFF0001});
        checkObs("clean_last_payload", 103, {2'b01, 32'hFFC1003F});

        // Same symbol with random backpressure
        bpMode = 1;
        applyReset();
        applyStimulus(N, N - 1, 0, 1);
        drainAndCheck("backpressure");
        checkOutput("bp_transfers_lit", 36'(obsQ.size()), 36'd104);
        checkObs("bp_last_payload", 103, {2'b01, 32'hFFC1003F});

        // Negation edge values
        bpMode = 0;
        applyReset();
        applyStimulus(N, N - 1, 2, 1);
        drainAndCheck("negation");
        checkObs("neg_8000", 40, {2'b00, 32'h80008000});
        checkObs("neg_7fff", 41, {2'b00, 32'h80018001});
        checkObs("neg_zero", 42, {2'b00, 32'h00000000});

        // Malformed: early EOP, overlong packet, then a clean one
        bpMode = 1;
        applyReset();
        applyStimulus(41, 40, 1, 1);
        applyStimulus(70, -1, 1, 1);
        applyStimulus(N, N - 1, 1, 1);
        drainAndCheck("malformed");
        checkOutput("malformed_errors_lit", 36'(obsErr), 36'd2);
        checkOutput("malformed_symbols_lit", 36'(symbol_count), 36'd1);

        // SOP restart mid-packet
        bpMode = 0;
        applyReset();
        applyStimulus(20, -1, 1, 0);
        applyStimulus(N, N - 1, 1, 1);
        drainAndCheck("restart");
        checkOutput("restart_errors_lit", 36'(obsErr), 36'd0);
        checkOutput("restart_symbols_lit", 36'(symbol_count), 36'd1);

        // Several random symbols back to back under backpressure
        bpMode = 1;
        applyReset();
        for (int s = 0; s < 3; s++) applyStimulus(N, N - 1, 1, 1);
        drainAndCheck("random");
        checkOutput("random_symbols_lit", 36'(symbol_count), 36'd3);

        // Reset asserted during payload beat 10
        bpMode = 0;
        applyReset();
        applyStimulus(N, N - 1, 1, 1);
        n = 0;
        while (xferCount < G + P + 10 && n < 3000) begin
            @(negedge clock_clk);
            n++;
        end
        checkOutput("reach_payload10_timeout", 36'(n >= 3000), 36'd0);
        #2;
        reset_reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        applyReset();
        applyStimulus(N, N - 1, 0, 1);
        drainAndCheck("after_reset");
        checkOutput("after_reset_symbols_lit", 36'(symbol_count), 36'd1);
        checkObs("after_reset_last_payload", 103, {2'b01, 32'hFFC1003F});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
